// File: rtl/mac_acc_pipe_if.sv
// Handshake and operand bundle between the operand buffers, mac_acc_pipe and psum writeback.
// The "slave" modport is the MAC's view; "master" is the upstream/downstream environment.
interface mac_acc_pipe_if #(
    parameter int DATA_W = 256,
    parameter int ACC_W  = 24,
    parameter int VSQ_W  = 8
);
    logic [1:0]        i_mode;
    logic              i_valid;
    logic              o_ready;
    logic              i_first;
    logic              i_last;
    logic [ACC_W-1:0]  i_psum;
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;
    logic [VSQ_W-1:0]  i_vsq_a;
    logic [VSQ_W-1:0]  i_vsq_b;
    logic              o_valid;
    logic              i_ready;
    logic [ACC_W-1:0]  o_result;
    logic              o_sat;

    modport slave (
        input  i_mode, i_valid, i_first, i_last, i_psum, i_a, i_b, i_vsq_a, i_vsq_b, i_ready,
        output o_ready, o_valid, o_result, o_sat
    );

    modport master (
        output i_mode, i_valid, i_first, i_last, i_psum, i_a, i_b, i_vsq_a, i_vsq_b, i_ready,
        input  o_ready, o_valid, o_result, o_sat
    );
endinterface

// File: rtl/mac_acc_pipe.sv
// Two-stage pipelined dot-product MAC (INT8/INT4/INT4_VSQ) with multi-beat group accumulation.
// Define MAC_SAT_EN for saturating accumulation with a sticky per-group o_sat; otherwise wrap.
module mac_acc_pipe #(
    parameter int DATA_W = 256,
    parameter int ACC_W  = 24,
    parameter int VSQ_W  = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    mac_acc_pipe_if.slave bus
);
    localparam int L8 = DATA_W / 8;
    localparam int L4 = DATA_W / 4;

    typedef logic signed [ACC_W:0]   wide_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef enum logic [1:0] {
        MODE_INT8 = 2'd0,
        MODE_INT4 = 2'd1,
        MODE_VSQ  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    mode_e mode_q;
    mode_e beat_mode;
    logic  stall;
    logic  accept;
    logic  s1_valid;
    logic  s1_first;
    logic  s1_last;
    acc_t  s1_psum;
    wide_t s1_term;
    wide_t term;
    wide_t dot8;
    wide_t dot4;
    wide_t vsq_s;
    wide_t sum;
    acc_t  acc_q;
    acc_t  acc_next;
    acc_t  res_q;
    logic  out_valid_q;

    // Valid/ready: a beat transfers on a rising edge where i_valid & o_ready; a result
    // transfers where o_valid & i_ready. A pending result with i_ready low freezes the pipe.
    assign stall        = out_valid_q & ~bus.i_ready;
    assign accept       = bus.i_valid & ~stall;
    assign bus.o_ready  = ~stall;
    assign bus.o_valid  = out_valid_q;
    assign bus.o_result = res_q;

    assign beat_mode = bus.i_first ? mode_e'(bus.i_mode) : mode_q;

    always_comb begin
        dot8 = '0;
        dot4 = '0;
        for (int i = 0; i < L8; i++) begin
            dot8 = dot8 + wide_t'($signed(bus.i_a[8*i +: 8])) * wide_t'($signed(bus.i_b[8*i +: 8]));
        end
        for (int i = 0; i < L4; i++) begin
            dot4 = dot4 + wide_t'($signed(bus.i_a[4*i +: 4])) * wide_t'($signed(bus.i_b[4*i +: 4]));
        end
        // Round-half-up scale: add half an LSB before the arithmetic shift.
        vsq_s = (wide_t'($signed(bus.i_vsq_a)) * wide_t'($signed(bus.i_vsq_b))
                 + (wide_t'(1) <<< (VSQ_W - 1))) >>> VSQ_W;
        case (beat_mode)
            MODE_INT4: term = dot4;
            MODE_VSQ:  term = dot4 * vsq_s;
            default:   term = dot8;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q   <= MODE_INT8;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_psum  <= '0;
            s1_term  <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= bus.i_first;
                s1_last  <= bus.i_last;
                s1_psum  <= bus.i_psum;
                s1_term  <= term;
                if (bus.i_first) mode_q <= beat_mode;
            end
        end
    end

    assign sum = (s1_first ? wide_t'(s1_psum) : wide_t'(acc_q)) + s1_term;

`ifdef MAC_SAT_EN
    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic ovf;
    logic sat_next;
    logic grp_sat_q;
    logic res_sat_q;

    always_comb begin
        ovf = sum[ACC_W] != sum[ACC_W-1];
        if (!ovf)          acc_next = sum[ACC_W-1:0];
        else if (sum[ACC_W]) acc_next = ACC_MIN;
        else               acc_next = ACC_MAX;
        sat_next = (s1_first ? 1'b0 : grp_sat_q) | ovf;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grp_sat_q <= 1'b0;
            res_sat_q <= 1'b0;
        end else if (!stall && s1_valid) begin
            grp_sat_q <= sat_next;
            if (s1_last) res_sat_q <= sat_next;
        end
    end

    assign bus.o_sat = res_sat_q;
`else
    logic unused_sum_top;
    assign acc_next       = sum[ACC_W-1:0];
    assign unused_sum_top = sum[ACC_W];
    assign bus.o_sat      = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            if (s1_valid) acc_q <= acc_next;
            if (s1_valid && s1_last) begin
                res_q       <= acc_next;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed-vector scoreboard bench for mac_acc_pipe; expectations are hand-computed for
// DATA_W=256 (32 INT8 / 64 INT4 lanes), ACC_W=24, VSQ_W=8. Honours MAC_SAT_EN.
module tb_mac_acc_pipe;
    localparam int DATA_W = 256;
    localparam int ACC_W  = 24;
    localparam int VSQ_W  = 8;
    localparam int L8     = DATA_W / 8;
    localparam int L4     = DATA_W / 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mac_acc_pipe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .VSQ_W(VSQ_W)) bus ();

    mac_acc_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .VSQ_W(VSQ_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [ACC_W:0] exp_q[$];
    string          name_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_exp   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic expect_result(input string name, input logic [ACC_W-1:0] res, input logic sat);
        exp_q.push_back({sat, res});
        name_q.push_back(name);
        n_exp++;
    endtask

    function automatic logic [DATA_W-1:0] rep8(input logic [7:0] v);
        return {L8{v}};
    endfunction

    function automatic logic [DATA_W-1:0] rep4(input logic [3:0] v);
        return {L4{v}};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one beat and hold it until the edge on which o_ready is high.
    task automatic send_beat(input logic first, input logic last, input logic [1:0] mode,
                             input logic [ACC_W-1:0] psum, input logic [DATA_W-1:0] a,
                             input logic [DATA_W-1:0] b, input logic [VSQ_W-1:0] va,
                             input logic [VSQ_W-1:0] vb);
        logic rdy;
        logic done;
        bus.i_valid = 1'b1;
        bus.i_first = first;
        bus.i_last  = last;
        bus.i_mode  = mode;
        bus.i_psum  = psum;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_vsq_a = va;
        bus.i_vsq_b = vb;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            rdy = bus.o_ready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        if (!done) fail_now("send_beat_timeout");
        bus.i_valid = 1'b0;
    endtask

    // Monitor: pops and compares on every output handshake.
    initial begin
        logic [ACC_W:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h, no result expected", bus.o_result);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, "_result"}, bus.o_result, e[ACC_W-1:0]);
                    check({nm, "_sat"}, bus.o_sat, e[ACC_W]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.i_valid = 1'b0;
        bus.i_first = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_mode  = 2'd0;
        bus.i_psum  = '0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_vsq_a = '0;
        bus.i_vsq_b = '0;
        bus.i_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Completed group (32*1 + 7 = 39), then a half-finished group killed by reset.
        expect_result("pre_reset", 24'h000027, 1'b0);
        send_beat(1'b1, 1'b1, 2'd0, 24'd7, rep8(8'd1), rep8(8'd1), '0, '0);
        send_beat(1'b1, 1'b0, 2'd0, 24'd500, rep8(8'd1), rep8(8'd1), '0, '0);
        idle(4);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_o_valid", bus.o_valid, 1'b0);
        check("rst_o_result", bus.o_result, 24'h0);
        check("rst_o_sat", bus.o_sat, 1'b0);
        check("rst_o_ready", bus.o_ready, 1'b1);
        @(posedge clk);
        #1;
        // Non-first beat after reset: accumulator starts at 0, mode latched INT8.
        expect_result("post_reset", 24'hFFFF40, 1'b0);
        send_beat(1'b0, 1'b1, 2'd1, 24'd999, rep8(8'd2), rep8(8'hFD), '0, '0);
        idle(4);

        // INT8 single beat with latency check: 100 + 32*(2*-3) = -92.
        expect_result("int8_single", 24'hFFFFA4, 1'b0);
        send_beat(1'b1, 1'b1, 2'd0, 24'd100, rep8(8'd2), rep8(8'hFD), '0, '0);
        @(negedge clk);
        check("lat_n1_valid", bus.o_valid, 1'b0);
        @(negedge clk);
        check("lat_n2_valid", bus.o_valid, 1'b1);
        idle(3);

        // INT4 three-beat group: 3 * 64 * 49 = 9408.
        n0 = n_out;
        expect_result("int4_group", 24'h0024C0, 1'b0);
        send_beat(1'b1, 1'b0, 2'd1, 24'd0, rep4(4'd7), rep4(4'd7), '0, '0);
        send_beat(1'b0, 1'b0, 2'd0, 24'd0, rep4(4'd7), rep4(4'd7), '0, '0);
        send_beat(1'b0, 1'b1, 2'd0, 24'd0, rep4(4'd7), rep4(4'd7), '0, '0);
        idle(6);
        check("int4_result_count", n_out - n0, 1);

        // INT4_VSQ: s = (64*64+128)>>>8 = 16 -> 64*16+10; s = (129+128)>>>8 = 1 -> 64.
        expect_result("vsq_64_64", 24'h00040A, 1'b0);
        send_beat(1'b1, 1'b1, 2'd2, 24'd10, rep4(4'd1), rep4(4'd1), 8'd64, 8'd64);
        expect_result("vsq_round", 24'h000040, 1'b0);
        send_beat(1'b1, 1'b1, 2'd2, 24'd0, rep4(4'd1), rep4(4'd1), 8'd3, 8'd43);
        // Chained beat keeps VSQ mode and continues from 64: 64 + 1024.
        expect_result("vsq_chain", 24'h000440, 1'b0);
        send_beat(1'b0, 1'b1, 2'd0, 24'd999, rep4(4'd1), rep4(4'd1), 8'd64, 8'd64);

        // Reserved mode behaves as INT8.
        expect_result("rsvd_mode", 24'hFFFF40, 1'b0);
        send_beat(1'b1, 1'b1, 2'd3, 24'd0, rep8(8'd2), rep8(8'hFD), '0, '0);

        // Overflow: 0x7FFFF0 + 32*16129.
`ifdef MAC_SAT_EN
        expect_result("overflow", 24'h7FFFFF, 1'b1);
`else
        expect_result("overflow", 24'h87E010, 1'b0);
`endif
        send_beat(1'b1, 1'b1, 2'd0, 24'h7FFFF0, rep8(8'd127), rep8(8'd127), '0, '0);
        idle(5);

        // Backpressure: result X = 32 stalls while group Y (3*64 + 5 = 197) streams in.
        bus.i_ready = 1'b0;
        expect_result("bp_first", 24'h000020, 1'b0);
        send_beat(1'b1, 1'b1, 2'd0, 24'd0, rep8(8'd1), rep8(8'd1), '0, '0);
        expect_result("bp_second", 24'h0000C5, 1'b0);
        fork
            begin
                send_beat(1'b1, 1'b0, 2'd1, 24'd5, rep4(4'd1), rep4(4'd1), '0, '0);
                send_beat(1'b0, 1'b0, 2'd1, 24'd0, rep4(4'd1), rep4(4'd1), '0, '0);
                send_beat(1'b0, 1'b1, 2'd1, 24'd0, rep4(4'd1), rep4(4'd1), '0, '0);
            end
            begin
                logic seen;
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = bus.o_valid;
                end
                if (!seen) fail_now("bp_wait_valid");
                check("bp_ready_low_start", bus.o_ready, 1'b0);
                check("bp_result_held_start", bus.o_result, 24'h000020);
                repeat (8) @(negedge clk);
                check("bp_ready_low_end", bus.o_ready, 1'b0);
                check("bp_valid_held_end", bus.o_valid, 1'b1);
                check("bp_result_held_end", bus.o_result, 24'h000020);
                @(posedge clk);
                #1 bus.i_ready = 1'b1;
            end
        join
        idle(10);

        check("total_results", n_out, n_exp);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
